// File: rtl/prog_loader_ctrl.sv
// Boot-time program loader: receives a 16-bit word count and then little-endian
// 32-bit words from a byte stream, writing them to instruction memory while holding the CPU.
module prog_loader_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [2:0]            fsm_state
);

    localparam int              TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam logic [32:0]     MAX_N  = 33'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        RECV  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t                state, next_state;
    logic                  load_req_q;
    logic                  rise;
    logic [1:0]            idx;
    logic [7:0]            hdr_lo;
    logic [15:0]           n_words;
    logic [15:0]           n_new;
    logic [15:0]           words_done;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [23:0]           word_buf;
    logic [TW-1:0]         tcnt;
    logic                  last_word;
    logic                  timed_out;

    // rx_valid is a one-cycle strobe with no backpressure: a byte is consumed
    // in the cycle it is presented or lost; imem_we is a one-cycle write pulse.
    assign rise      = load_req & ~load_req_q;
    assign n_new     = {rx_byte, hdr_lo};
    assign last_word = (words_done + 16'd1) == n_words;
    assign timed_out = (tcnt == T_LAST) && !rx_valid;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, ERR: if (rise) next_state = HDR;
            HDR: begin
                if (timed_out) next_state = ERR;
                else if (rx_valid && idx[0]) begin
                    if (n_new == 16'd0)              next_state = DONE;
                    else if ({17'd0, n_new} > MAX_N) next_state = ERR;
                    else                             next_state = RECV;
                end
            end
            RECV: begin
                if (timed_out)                    next_state = ERR;
                else if (rx_valid && idx == 2'd3) next_state = WRITE;
            end
            WRITE:   next_state = last_word ? DONE : RECV;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        imem_we   = (state == WRITE);
        busy      = (state == HDR) || (state == RECV) || (state == WRITE);
        cpu_hold  = (state != IDLE);
        fsm_state = state;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            load_req_q <= 1'b0;
            idx        <= 2'd0;
            hdr_lo     <= 8'd0;
            n_words    <= 16'd0;
            words_done <= 16'd0;
            word_addr  <= '0;
            word_buf   <= 24'd0;
            tcnt       <= '0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            load_req_q <= load_req;
            case (state)
                IDLE, ERR: begin
                    if (rise) begin
                        idx        <= 2'd0;
                        words_done <= 16'd0;
                        word_addr  <= '0;
                        tcnt       <= '0;
                        load_done  <= 1'b0;
                        load_err   <= 1'b0;
                    end
                end
                HDR: begin
                    if (rx_valid) begin
                        tcnt <= '0;
                        if (!idx[0]) begin
                            hdr_lo <= rx_byte;
                            idx    <= 2'd1;
                        end else begin
                            n_words <= n_new;
                            idx     <= 2'd0;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        tcnt <= '0;
                        idx  <= idx + 2'd1;
                        case (idx)
                            2'd0: word_buf[7:0]   <= rx_byte;
                            2'd1: word_buf[15:8]  <= rx_byte;
                            2'd2: word_buf[23:16] <= rx_byte;
                            default: begin
                                imem_wdata <= {rx_byte, word_buf};
                                imem_addr  <= word_addr;
                            end
                        endcase
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WRITE: begin
                    word_addr  <= word_addr + 1'b1;
                    words_done <= words_done + 16'd1;
                    // A byte arriving alongside the write starts the next word,
                    // unless this write was the last one of the load.
                    if (rx_valid && !last_word) begin
                        word_buf[7:0] <= rx_byte;
                        idx           <= 2'd1;
                        tcnt          <= '0;
                    end
                end
                default: ;
            endcase
            if (next_state == DONE) load_done <= 1'b1;
            if (next_state == ERR)  load_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Directed bench for prog_loader_ctrl: expected memory writes go into a queue
// that a negedge monitor drains; status outputs are checked inline.
module tb_prog_loader_ctrl;

    localparam int AW = 14;
    localparam int TO = 16;
    localparam int W  = AW + 32;

    logic          clock = 1'b0;
    logic          rst = 1'b0;
    logic          load_req = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'd0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          load_done;
    logic          load_err;
    logic [2:0]    fsm_state;

    logic [W-1:0]  exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            k;

    prog_loader_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clock(clock), .rst(rst), .load_req(load_req), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .busy(busy),
        .load_done(load_done), .load_err(load_err), .fsm_state(fsm_state)
    );

    // clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (imem_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", imem_addr, imem_wdata);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e)
                begin
                    n_fail++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             imem_addr, imem_wdata, e[W-1:32], e[31:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send(n[7:0]);
        send(n[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        send(w[31:24]);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // sel 0 waits for load_done, sel 1 for load_err; returns cycles waited, 0 if never
    task automatic wait_flag(input int sel, output int cycles);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if ((sel == 0 && load_done) || (sel == 1 && load_err)) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        // reset state
        #2;
        check("rst_outputs", {imem_we, imem_addr, imem_wdata, cpu_hold, busy, load_done, load_err}, 0);
        check("rst_state", fsm_state, 0);
        #20;
        rst = 1'b1;
        tick();

        // two-word program, second word starts during the first write
        push(0, 32'h20010013);
        push(1, 32'h03E00008);
        pulse_load();
        check("load_hold", {cpu_hold, busy}, 2'b11);
        send_hdr(16'd2);
        send_word(32'h20010013);
        send_word(32'h03E00008);
        wait_flag(0, k);
        check("prog2_done_lat", k, 1);
        check("prog2_done_state", {fsm_state, cpu_hold, load_done}, {3'd4, 2'b11});
        tick();
        check("prog2_release", {fsm_state, cpu_hold, busy, load_done, load_err}, {3'd0, 4'b0010});
        check("prog2_hold_addr", imem_addr, 1);

        // empty program
        tick();
        pulse_load();
        check("empty_clear_done", load_done, 0);
        send_hdr(16'd0);
        check("empty_done", {fsm_state, cpu_hold, load_done}, {3'd4, 2'b11});
        tick();
        check("empty_idle", {fsm_state, cpu_hold}, {3'd0, 1'b0});

        // timeout mid-word
        pulse_load();
        send_hdr(16'd1);
        send(8'hAA);
        send(8'hBB);
        wait_flag(1, k);
        check("timeout_cycles", k, TO);
        check("timeout_err", {fsm_state, load_err, cpu_hold, busy, load_done}, {3'd5, 4'b1100});
        tick();
        check("err_sticky", {fsm_state, load_err, cpu_hold}, {3'd5, 2'b11});

        // back-to-back bytes from ERR, plus a trailing byte to be discarded
        push(0, 32'h11223344);
        push(1, 32'hA5A55A5A);
        push(2, 32'hDEADBEEF);
        pulse_load();
        check("restart_from_err", {fsm_state, load_err}, {3'd1, 1'b0});
        send_hdr(16'd3);
        send_word(32'h11223344);
        send_word(32'hA5A55A5A);
        send_word(32'hDEADBEEF);
        send(8'h77);
        check("b2b_done", {fsm_state, load_done}, {3'd4, 1'b1});
        tick();

        // reset during word 1
        push(0, 32'h04030201);
        pulse_load();
        send_hdr(16'd2);
        send_word(32'h04030201);
        send(8'h55);
        send(8'h66);
        rst = 1'b0;
        #1;
        check("midrst_outputs", {imem_we, imem_addr, imem_wdata, cpu_hold, busy, load_done, load_err}, 0);
        check("midrst_state", fsm_state, 0);
        #30;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("postrst_idle", {fsm_state, cpu_hold, busy}, 0);
        push(0, 32'hCAFEF00D);
        pulse_load();
        send_hdr(16'd1);
        send_word(32'hCAFEF00D);
        wait_flag(0, k);
        check("postrst_done_lat", k, 1);

        // load_req toggling during a load is ignored
        tick();
        push(0, 32'h12345678);
        push(1, 32'h9ABCDEF0);
        pulse_load();
        send_hdr(16'd2);
        send_word(32'h12345678);
        load_req = 1'b1;
        send(8'hF0);
        send(8'hDE);
        load_req = 1'b0;
        send(8'hBC);
        send(8'h9A);
        wait_flag(0, k);
        check("toggle_done_lat", k, 1);

        // header one above the address space
        tick();
        pulse_load();
        send_hdr(16'h4001);
        check("too_big_err", {fsm_state, load_err, cpu_hold}, {3'd5, 2'b11});

        // header exactly the address space size is accepted
        pulse_load();
        send_hdr(16'h4000);
        check("max_n_recv", {fsm_state, load_err, busy}, {3'd2, 2'b01});
        wait_flag(1, k);
        check("max_n_timeout", k, TO);

        for (int i = 0; i < 5; i++) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
